gat_feat_reader: RTL and testbench

- Host-side read engine for the new-feature BRAM: the consumer end of the feature read port (byte address out, 32-bit data in).
- After the GAT core reports ready, sweeps all NUM_SUBGRAPHS*NUM_FEATURE_OUT words in order and streams them out on a valid/ready master stream.
- Stream carries per-node and end-of-frame markers, so DMA/PS logic can drain results without per-word register-bank polling.
- Absorbs fixed BRAM read latency with a credit-controlled skid FIFO.

---
 rtl/gat_pkg.sv | 26 ++
 rtl/gat_sync_fifo.sv | 60 ++++++
 rtl/gat_feat_reader.sv | 159 +++++++++++++++
 tb/tb_gat_feat_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// ----------------------------------------------------------------------------
// gat_pkg
// Shared types and constants for the GAT feature read path.
//   feat_beat_t  : one stream beat (feature word plus node/frame end markers)
//   rd_state_e   : read-engine FSM states
//   ADDR_SHIFT   : word index to byte address shift (32-bit words)
// ----------------------------------------------------------------------------
package gat_pkg;

    localparam int FEAT_W     = 32;
    localparam int ADDR_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_RDY = 2'd1,
        ST_READ     = 2'd2,
        ST_DRAIN    = 2'd3
    } rd_state_e;

    typedef struct packed {
        logic [FEAT_W-1:0] data;
        logic              node_last;
        logic              last;
    } feat_beat_t;

endpackage

// File: rtl/gat_sync_fifo.sv
// ----------------------------------------------------------------------------
// gat_sync_fifo
// Single-clock FIFO with occupancy count, for stream adapters.
// DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pointers/count only)
//   push        : write push_data (ignored when full)
//   pop         : drop head entry (ignored when empty)
//   head_data   : current head entry
//   empty       : no entries held
//   count       : number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module gat_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push & (count_q != CNT_W'(DEPTH));
    assign do_pop    = pop & (count_q != '0);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/gat_feat_reader.sv
// ----------------------------------------------------------------------------
// gat_feat_reader
// Sweeps the new-feature BRAM once per start request and streams every word
// out on a valid/ready master, tagging the last word of each node and of the
// frame. BRAM read latency is absorbed by a credit-limited skid FIFO.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle frame request (ignored while busy)
//   gat_ready         : core level, features readable while high
//   busy / done       : frame in progress / one-cycle completion pulse
//   feat_bram_enb     : BRAM read enable
//   feat_bram_addrb   : BRAM byte address (word index << 2)
//   feat_bram_dout    : BRAM read data, RD_LATENCY cycles after enb
//   m_tdata/m_tvalid/m_tready/m_tnode_last/m_tlast : output stream
// ----------------------------------------------------------------------------
module gat_feat_reader
    import gat_pkg::*;
#(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            gat_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            feat_bram_enb,
    output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tnode_last,
    output logic                            m_tlast
);

    localparam int NODE_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W  = CNT_W + 1;
    localparam int BEAT_W = $bits(feat_beat_t);

    rd_state_e                    state_q;
    rd_state_e                    state_d;
    logic [NEW_FEATURE_ADDR_W-1:0] issue_idx_q;
    logic [NODE_W-1:0]            node_cnt_q;
    logic [RD_LATENCY-1:0]        enb_pipe_q;
    logic [RD_LATENCY-1:0]        node_last_pipe_q;
    logic [RD_LATENCY-1:0]        last_pipe_q;
    logic                         done_q;

    logic                         enb;
    logic                         issue_node_last;
    logic                         issue_last;
    logic [CNT_W-1:0]             outstanding;
    logic [CNT_W-1:0]             fifo_count;
    logic [SUM_W-1:0]             credit_sum;
    logic                         credit_ok;
    logic                         fifo_empty;
    logic                         hs;
    feat_beat_t                   push_beat;
    feat_beat_t                   head_beat;

    assign issue_last      = (issue_idx_q == NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1));
    assign issue_node_last = (node_cnt_q == NODE_W'(NUM_FEATURE_OUT - 1));

    // Credit uses only registered occupancy: a slot freed by this cycle's
    // handshake becomes usable one cycle later.
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            outstanding = outstanding + CNT_W'(enb_pipe_q[i]);
        end
    end

    assign credit_sum = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign credit_ok  = (credit_sum < SUM_W'(FIFO_DEPTH));
    assign hs         = ~fifo_empty & m_tready;

    always_comb begin
        state_d = state_q;
        enb     = 1'b0;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: if (gat_ready) state_d = ST_READ;
            ST_READ: begin
                enb = gat_ready & credit_ok;
                if (enb && issue_last) state_d = ST_DRAIN;
            end
            ST_DRAIN:    if (hs && head_beat.last) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Stage p0: issue side (FSM, counters, latency pipe occupancy)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            issue_idx_q <= '0;
            node_cnt_q  <= '0;
            enb_pipe_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= (state_q == ST_DRAIN) && hs && head_beat.last;
            enb_pipe_q <= (enb_pipe_q << 1) | RD_LATENCY'(enb);
            if (state_q == ST_IDLE && start) begin
                issue_idx_q <= '0;
                node_cnt_q  <= '0;
            end else if (enb) begin
                issue_idx_q <= issue_last ? '0 : issue_idx_q + NEW_FEATURE_ADDR_W'(1);
                node_cnt_q  <= issue_node_last ? '0 : node_cnt_q + NODE_W'(1);
            end
        end
    end

    // Stage p1..pN: tags travel alongside the read, qualified by enb_pipe_q
    always_ff @(posedge clk) begin
        node_last_pipe_q <= (node_last_pipe_q << 1) | RD_LATENCY'(issue_node_last);
        last_pipe_q      <= (last_pipe_q << 1) | RD_LATENCY'(issue_last);
    end

    always_comb begin
        push_beat.data      = feat_bram_dout;
        push_beat.node_last = node_last_pipe_q[RD_LATENCY-1];
        push_beat.last      = last_pipe_q[RD_LATENCY-1];
    end

    // Stage out: skid FIFO feeding the stream
    gat_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (enb_pipe_q[RD_LATENCY-1]),
        .push_data (push_beat),
        .pop       (hs),
        .head_data (head_beat),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign feat_bram_enb   = enb;
    assign feat_bram_addrb = {issue_idx_q, {ADDR_SHIFT{1'b0}}};
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign m_tvalid        = ~fifo_empty;
    // Head storage is not reset, so outputs are zeroed while nothing is valid.
    assign m_tdata         = fifo_empty ? '0 : head_beat.data;
    assign m_tnode_last    = ~fifo_empty & head_beat.node_last;
    assign m_tlast         = ~fifo_empty & head_beat.last;

endmodule

// File: tb/tb_gat_feat_reader.sv
module tb_gat_feat_reader;

    localparam int NS    = 3;
    localparam int NF    = 4;
    localparam int DEPTH = NS * NF;
    localparam int AW    = $clog2(DEPTH);
    localparam int W     = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          gat_ready;
    logic          busy;
    logic          done;
    logic          feat_bram_enb;
    logic [AW+1:0] feat_bram_addrb;
    logic [W-1:0]  feat_bram_dout;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tnode_last;
    logic          m_tlast;

    always #5 clk = ~clk;

    gat_feat_reader #(
        .NEW_FEATURE_WIDTH (W),
        .NUM_SUBGRAPHS     (NS),
        .NUM_FEATURE_OUT   (NF),
        .RD_LATENCY        (2),
        .FIFO_DEPTH        (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .gat_ready       (gat_ready),
        .busy            (busy),
        .done            (done),
        .feat_bram_enb   (feat_bram_enb),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_dout  (feat_bram_dout),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tnode_last    (m_tnode_last),
        .m_tlast         (m_tlast)
    );

    // BRAM model: two-cycle read latency, content = word index + 0x100
    logic [W-1:0] bram_r1, bram_r2;
    always_ff @(posedge clk) begin
        bram_r1 <= 32'(feat_bram_addrb >> 2) + 32'h100;
        bram_r2 <= bram_r1;
    end
    assign feat_bram_dout = bram_r2;

    int total  = 0;
    int passed = 0;

    int rx_data[$];
    int rx_nl[$];
    int rx_last[$];
    int addr_log[$];
    int enb_cyc[$];
    int done_cnt, first_hs, last_hs, max_inflight;
    int stall_bad, gr_bad, busy_bad, done_busy_bad;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int tr_mode, input int gr_low, input bit drop, input int restart_cyc);
        int drop_s;
        int issued;
        int delivered;
        int after_done;
        bit prev_stall;
        logic [W-1:0] prev_d;
        logic prev_nl, prev_l;
        rx_data.delete(); rx_nl.delete(); rx_last.delete();
        addr_log.delete(); enb_cyc.delete();
        done_cnt = 0; first_hs = -1; last_hs = -1; max_inflight = 0;
        stall_bad = 0; gr_bad = 0; busy_bad = 0; done_busy_bad = 0;
        drop_s = -1; issued = 0; delivered = 0; after_done = -1;
        prev_stall = 1'b0; prev_d = '0; prev_nl = 1'b0; prev_l = 1'b0;
        for (int c = 0; c < 400; c++) begin
            start     = (c == 0) || (c == restart_cyc);
            gat_ready = (c > gr_low) && !(drop_s >= 0 && c > drop_s && c <= drop_s + 5);
            m_tready  = (tr_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            #1;
            if (c >= 1 && c <= gr_low && !(busy && !feat_bram_enb)) busy_bad++;
            if (!gat_ready && feat_bram_enb) gr_bad++;
            if (prev_stall && !(m_tvalid && m_tdata === prev_d &&
                                m_tnode_last === prev_nl && m_tlast === prev_l)) stall_bad++;
            if (feat_bram_enb) begin
                addr_log.push_back(int'(feat_bram_addrb));
                enb_cyc.push_back(c);
                issued++;
                if (drop && feat_bram_addrb == 20) drop_s = c;
            end
            if (issued - delivered > max_inflight) max_inflight = issued - delivered;
            if (m_tvalid && m_tready) begin
                rx_data.push_back(int'(m_tdata));
                rx_nl.push_back(int'(m_tnode_last));
                rx_last.push_back(int'(m_tlast));
                if (first_hs < 0) first_hs = c;
                last_hs = c;
                delivered++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata; prev_nl = m_tnode_last; prev_l = m_tlast;
            if (done) begin
                done_cnt++;
                if (busy) done_busy_bad++;
                if (after_done < 0) after_done = c;
            end
            if (after_done >= 0 && c >= after_done + 2) begin
                start = 1'b0;
                break;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic check_frame(input string name);
        chk({name, " word_count"}, rx_data.size(), DEPTH);
        chk({name, " issue_count"}, addr_log.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < rx_data.size()) begin
                chk($sformatf("%s data[%0d]", name, i), rx_data[i], 32'h100 + i);
                chk($sformatf("%s node_last[%0d]", name, i), rx_nl[i], (i % NF == NF - 1) ? 1 : 0);
                chk($sformatf("%s last[%0d]", name, i), rx_last[i], (i == DEPTH - 1) ? 1 : 0);
            end
            if (i < addr_log.size())
                chk($sformatf("%s addrb[%0d]", name, i), addr_log[i], i * 4);
        end
        chk({name, " done_pulses"}, done_cnt, 1);
        chk({name, " done_with_busy"}, done_busy_bad, 0);
        chk({name, " stall_stability"}, stall_bad, 0);
        chk({name, " inflight_le_4"}, (max_inflight <= 4) ? 1 : 0, 1);
        chk({name, " enb_while_not_ready"}, gr_bad, 0);
        chk({name, " busy_after"}, busy, 0);
    endtask

    initial begin
        bit hit;
        int dcnt;
        rst = 1'b1; start = 1'b0; gat_ready = 1'b0; m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset enb", feat_bram_enb, 0);
        chk("reset addrb", feat_bram_addrb, 0);
        chk("reset tvalid", m_tvalid, 0);
        chk("reset tdata", m_tdata, 0);
        tick();

        // Full-rate frame
        run_frame(0, 0, 1'b0, -1);
        check_frame("s1");
        chk("s1 first_enb_cycle", enb_cyc.size() > 0 ? enb_cyc[0] : -1, 2);
        chk("s1 first_word_latency", (enb_cyc.size() > 0) ? first_hs - enb_cyc[0] : -1, 3);
        chk("s1 back_to_back", last_hs - first_hs, DEPTH - 1);

        // Backpressure 1,0,0,1
        run_frame(1, 0, 1'b0, -1);
        check_frame("s2");

        // gat_ready low for 10 cycles after start
        run_frame(0, 10, 1'b0, -1);
        check_frame("s3");
        chk("s3 busy_no_enb_while_waiting", busy_bad, 0);
        chk("s3 first_enb_cycle", enb_cyc.size() > 0 ? enb_cyc[0] : -1, 12);

        // gat_ready dropped for 5 cycles after word 5 issues
        run_frame(0, 0, 1'b1, -1);
        check_frame("s4");
        chk("s4 resume_gap", (enb_cyc.size() > 6) ? enb_cyc[6] - enb_cyc[5] : -1, 6);

        // Reset during word 7
        hit = 1'b0;
        for (int c = 0; c < 60; c++) begin
            start = (c == 0); gat_ready = 1'b1; m_tready = 1'b1;
            #1;
            if (feat_bram_enb && feat_bram_addrb == 28) begin
                rst = 1'b1;
                hit = 1'b1;
                tick();
                break;
            end
            tick();
        end
        rst = 1'b0; start = 1'b0;
        #1;
        chk("s5 reached_word7", hit, 1);
        chk("s5 busy", busy, 0);
        chk("s5 done", done, 0);
        chk("s5 enb", feat_bram_enb, 0);
        chk("s5 addrb", feat_bram_addrb, 0);
        chk("s5 tvalid", m_tvalid, 0);
        chk("s5 tdata", m_tdata, 0);
        chk("s5 tnode_last", m_tnode_last, 0);
        chk("s5 tlast", m_tlast, 0);
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) dcnt++;
            tick();
        end
        chk("s5 no_done_after_reset", dcnt, 0);
        run_frame(0, 0, 1'b0, -1);
        check_frame("s5b");

        // Start while busy is ignored, then a second frame after done
        run_frame(0, 0, 1'b0, 5);
        check_frame("s6a");
        run_frame(0, 0, 1'b0, -1);
        check_frame("s6b");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
